uart_sfr_ctrl: RTL and testbench

UART_SFR_CTRL -- requirements
Module: uart_sfr_ctrl

---
 rtl/uart_sfr_ctrl_if.sv | 20 ++
 rtl/uart_sfr_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_sfr_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_sfr_ctrl_if.sv
// APB-side register access bus between the APB slave front end and uart_sfr_ctrl.
// Signal suffixes are written from the register block's point of view.
interface uart_sfr_ctrl_if;
   logic        wr_en_i;
   logic        rd_en_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        pready_o;

   modport slave (
      input  wr_en_i, rd_en_i, addr_i, wdata_i,
      output rdata_o, pready_o
   );

   modport master (
      output wr_en_i, rd_en_i, addr_i, wdata_i,
      input  rdata_o, pready_o
   );
endinterface

// File: rtl/uart_sfr_ctrl.sv
// UART special-function-register block: DATA/CTRL/BAUD/STATUS/IER map,
// TX push / RX pop strobes, sticky error flags and a registered interrupt.
module uart_sfr_ctrl #(
   parameter logic [15:0] BAUD_RST = 16'd54
) (
   input  logic              pclk,
   input  logic              presetn,
   uart_sfr_ctrl_if.slave    bus,
   output logic              tx_push_o,
   output logic [7:0]        tx_data_o,
   input  logic              tx_full_i,
   input  logic              tx_empty_i,
   output logic              rx_pop_o,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_empty_i,
   input  logic              overrun_i,
   output logic [7:0]        ctrl_o,
   output logic [15:0]       baud_div_o,
   output logic              irq_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_ACK   = 2'd1,
      RD_FETCH = 2'd2,
      RD_ACK   = 2'd3
   } state_t;

   localparam logic [2:0] OFF_DATA   = 3'd0;
   localparam logic [2:0] OFF_CTRL   = 3'd1;
   localparam logic [2:0] OFF_BAUD   = 3'd2;
   localparam logic [2:0] OFF_STATUS = 3'd3;
   localparam logic [2:0] OFF_IER    = 3'd4;

   state_t      state_q;
   logic [2:0]  off_q;
   logic [31:0] rdata_q;
   logic [4:0]  ctrl_q;
   logic [15:0] baud_q;
   logic [3:0]  ier_q;
   logic        rx_ovr_q, rx_ovr_d;
   logic        tx_ovf_q, tx_ovf_d;
   logic        tx_push_q;
   logic [7:0]  tx_data_q;
   logic        irq_q, irq_d;

   logic [2:0]  wr_off;
   logic        do_wr;
   logic [31:0] rd_mux;
   logic        unused_bits;

   assign wr_off = bus.addr_i[4:2];
   assign do_wr  = (state_q == IDLE) && bus.wr_en_i;
   assign unused_bits = ^{bus.addr_i[31:5], bus.addr_i[1:0], bus.wdata_i[31:16]};

   // Set events win over a coincident write-one-to-clear.
   always_comb begin
      rx_ovr_d = (rx_ovr_q & ~(do_wr && wr_off == OFF_STATUS && bus.wdata_i[3])) | overrun_i;
      tx_ovf_d = (tx_ovf_q & ~(do_wr && wr_off == OFF_STATUS && bus.wdata_i[4]))
               | (do_wr && wr_off == OFF_DATA && tx_full_i);
      irq_d    = |(ier_q & {tx_ovf_q, rx_ovr_q, tx_empty_i, ~rx_empty_i});
   end

   always_comb begin
      rd_mux = 32'd0;
      case (off_q)
         OFF_DATA:   rd_mux = rx_empty_i ? 32'd0 : {24'd0, rx_data_i};
         OFF_CTRL:   rd_mux = {27'd0, ctrl_q};
         OFF_BAUD:   rd_mux = {16'd0, baud_q};
         OFF_STATUS: rd_mux = {27'd0, tx_ovf_q, rx_ovr_q, rx_empty_i, tx_empty_i, tx_full_i};
         OFF_IER:    rd_mux = {28'd0, ier_q};
         default:    rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= IDLE;
         off_q     <= 3'd0;
         rdata_q   <= 32'd0;
         ctrl_q    <= 5'd0;
         baud_q    <= BAUD_RST;
         ier_q     <= 4'd0;
         rx_ovr_q  <= 1'b0;
         tx_ovf_q  <= 1'b0;
         tx_push_q <= 1'b0;
         tx_data_q <= 8'd0;
         irq_q     <= 1'b0;
      end else begin
         rx_ovr_q  <= rx_ovr_d;
         tx_ovf_q  <= tx_ovf_d;
         irq_q     <= irq_d;
         tx_push_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.wr_en_i) begin
                  case (wr_off)
                     OFF_DATA: begin
                        if (!tx_full_i) begin
                           tx_push_q <= 1'b1;
                           tx_data_q <= bus.wdata_i[7:0];
                        end
                     end
                     OFF_CTRL: ctrl_q <= bus.wdata_i[4:0];
                     OFF_BAUD: baud_q <= bus.wdata_i[15:0];
                     OFF_IER:  ier_q  <= bus.wdata_i[3:0];
                     default:  ;
                  endcase
                  state_q <= WR_ACK;
               end else if (bus.rd_en_i) begin
                  off_q   <= bus.addr_i[4:2];
                  state_q <= RD_FETCH;
               end
            end
            WR_ACK:   state_q <= IDLE;
            RD_FETCH: begin
               rdata_q <= rd_mux;
               state_q <= RD_ACK;
            end
            RD_ACK:   state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

   // The pop coincides with the edge that captures the show-ahead head byte.
   assign rx_pop_o     = (state_q == RD_FETCH) && (off_q == OFF_DATA) && !rx_empty_i;
   assign bus.pready_o = (state_q == WR_ACK) || (state_q == RD_ACK);
   assign bus.rdata_o  = (state_q == RD_ACK) ? rdata_q : 32'd0;
   assign tx_push_o    = tx_push_q;
   assign tx_data_o    = tx_data_q;
   assign ctrl_o       = {3'd0, ctrl_q};
   assign baud_div_o   = baud_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_uart_sfr_ctrl.sv
// Randomized bench for uart_sfr_ctrl: a transaction-level register model
// predicts every output, checked on each falling clock edge.
module tb_uart_sfr_ctrl;

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        tx_push, rx_pop, irq;
   logic [7:0]  tx_data, ctrl;
   logic [15:0] baud;
   logic        tx_full = 1'b0, tx_empty = 1'b1, rx_empty = 1'b1, overrun = 1'b0;
   logic [7:0]  rx_data = 8'd0;

   int checks = 0;
   int errors = 0;

   // Register model and per-cycle expectations
   logic [4:0]  m_ctrl;
   logic [15:0] m_baud;
   logic [3:0]  m_ier;
   logic        m_rx_ovr, m_tx_ovf;
   logic        exp_pready, exp_push, exp_pop;
   logic [7:0]  exp_txdata;
   logic [31:0] exp_rdata;
   logic        irq_stash = 1'b0;

   always #5 pclk = ~pclk;

   uart_sfr_ctrl_if bus ();

   uart_sfr_ctrl #(.BAUD_RST(16'd54)) dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .bus        (bus),
      .tx_push_o  (tx_push),
      .tx_data_o  (tx_data),
      .tx_full_i  (tx_full),
      .tx_empty_i (tx_empty),
      .rx_pop_o   (rx_pop),
      .rx_data_i  (rx_data),
      .rx_empty_i (rx_empty),
      .overrun_i  (overrun),
      .ctrl_o     (ctrl),
      .baud_div_o (baud),
      .irq_o      (irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ctrl = 5'd0;  m_baud = 16'd54; m_ier = 4'd0;
      m_rx_ovr = 1'b0; m_tx_ovf = 1'b0;
      exp_pready = 1'b0; exp_push = 1'b0; exp_pop = 1'b0;
      exp_txdata = 8'd0; exp_rdata = 32'd0;
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] off);
      case (off)
         3'd0:    return rx_empty ? 32'd0 : {24'd0, rx_data};
         3'd1:    return {27'd0, m_ctrl};
         3'd2:    return {16'd0, m_baud};
         3'd3:    return {27'd0, m_tx_ovf, m_rx_ovr, rx_empty, tx_empty, tx_full};
         3'd4:    return {28'd0, m_ier};
         default: return 32'd0;
      endcase
   endfunction

   // Single compare process: every output, every cycle.
   always @(negedge pclk) begin
      chk("pready", {31'd0, bus.pready_o}, {31'd0, exp_pready});
      chk("rdata", bus.rdata_o, exp_rdata);
      chk("tx_push", {31'd0, tx_push}, {31'd0, exp_push});
      if (exp_push) chk("tx_data", {24'd0, tx_data}, {24'd0, exp_txdata});
      chk("rx_pop", {31'd0, rx_pop}, {31'd0, exp_pop});
      chk("ctrl", {24'd0, ctrl}, {27'd0, m_ctrl});
      chk("baud", {16'd0, baud}, {16'd0, m_baud});
      chk("irq", {31'd0, irq}, {31'd0, presetn ? irq_stash : 1'b0});
      irq_stash = presetn && (|(m_ier & {m_tx_ovf, m_rx_ovr, tx_empty, ~rx_empty}));
   end

   // All stimulus tasks start and end 1 ns after a rising edge.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic ovr);
      bus.wr_en_i = 1'b1; bus.addr_i = a; bus.wdata_i = d; overrun = ovr;
      @(posedge pclk); #1;
      overrun = 1'b0;
      case (a[4:2])
         3'd0: if (tx_full) m_tx_ovf = 1'b1;
               else begin exp_push = 1'b1; exp_txdata = d[7:0]; end
         3'd1: m_ctrl = d[4:0];
         3'd2: m_baud = d[15:0];
         3'd3: begin
            if (d[3]) m_rx_ovr = 1'b0;
            if (d[4]) m_tx_ovf = 1'b0;
         end
         3'd4: m_ier = d[3:0];
         default: ;
      endcase
      if (ovr) m_rx_ovr = 1'b1;
      exp_pready = 1'b1;
      @(posedge pclk); #1;
      bus.wr_en_i = 1'b0;
      exp_pready = 1'b0; exp_push = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] got);
      logic [31:0] val;
      bus.rd_en_i = 1'b1; bus.addr_i = a;
      @(posedge pclk); #1;
      bus.rd_en_i = 1'b0;
      exp_pop = (a[4:2] == 3'd0) && !rx_empty;
      val = model_read(a[4:2]);
      @(posedge pclk); #1;
      exp_pop = 1'b0; exp_pready = 1'b1; exp_rdata = val;
      @(negedge pclk);
      got = bus.rdata_o;
      @(posedge pclk); #1;
      exp_pready = 1'b0; exp_rdata = 32'd0;
   endtask

   task automatic idle_cycle(input logic ovr);
      overrun = ovr;
      @(posedge pclk); #1;
      overrun = 1'b0;
      if (ovr) m_rx_ovr = 1'b1;
   endtask

   task automatic do_reset();
      presetn = 1'b0;
      bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0; overrun = 1'b0;
      model_reset();
      repeat (2) @(posedge pclk);
      #1 presetn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      logic [31:0] a, d;
      int op;
      bus.wr_en_i = 1'b0; bus.rd_en_i = 1'b0;
      bus.addr_i = 32'd0; bus.wdata_i = 32'd0;
      model_reset();
      repeat (3) @(posedge pclk);
      #1 presetn = 1'b1;

      do_read(32'h08, got);             chk("baud_rst_read", got, 32'd54);
      do_write(32'h04, 32'h1F, 1'b0);
      do_read(32'h04, got);             chk("ctrl_read", got, 32'h1F);
      chk("ctrl_o_lit", {24'd0, ctrl}, 32'h1F);

      tx_full = 1'b0; do_write(32'h00, 32'hA5, 1'b0);
      tx_full = 1'b1; do_write(32'h00, 32'hA5, 1'b0);
      do_read(32'h0C, got);             chk("tx_ovf_lit", {31'd0, got[4]}, 32'd1);
      tx_full = 1'b0;

      rx_data = 8'h3C; rx_empty = 1'b0;
      do_read(32'h00, got);             chk("rx_read_lit", got, 32'h3C);
      rx_empty = 1'b1;
      do_read(32'h00, got);             chk("rx_empty_lit", got, 32'd0);
      do_read(32'h18, got);             chk("unmapped_lit", got, 32'd0);

      do_write(32'h10, 32'h4, 1'b0);
      idle_cycle(1'b1);
      idle_cycle(1'b0);
      chk("irq_set_lit", {31'd0, irq}, 32'd1);
      do_write(32'h0C, 32'h08, 1'b0);
      idle_cycle(1'b0);
      chk("irq_clr_lit", {31'd0, irq}, 32'd0);
      do_write(32'h0C, 32'h08, 1'b1);
      do_read(32'h0C, got);             chk("w1c_race_lit", {31'd0, got[3]}, 32'd1);

      // Reset while the DATA read sits in RD_FETCH
      rx_data = 8'h77; rx_empty = 1'b0;
      bus.rd_en_i = 1'b1; bus.addr_i = 32'h0;
      @(posedge pclk); #1;
      do_reset();
      do_write(32'h04, 32'h15, 1'b0);
      do_read(32'h04, got);             chk("post_rst_lit", got, 32'h15);

      for (int i = 0; i < 300; i++) begin
         tx_full  = 1'($urandom_range(0, 1));
         tx_empty = 1'($urandom_range(0, 1));
         rx_empty = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom);
         a = $urandom;
         a[4:2] = 3'($urandom_range(0, 7));
         d = $urandom;
         op = $urandom_range(0, 2);
         if (op == 0)      do_write(a, d, ($urandom_range(0, 7) == 0));
         else if (op == 1) do_read(a, got);
         else              idle_cycle(($urandom_range(0, 3) == 0));
      end

      repeat (2) @(posedge pclk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
